clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_pkg.sv | 45 ++++
 rtl/clint_if.sv | 20 ++
 rtl/clint.sv | 177 +++++++++++++++++
 tb/tb_clint.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CSR addresses, cause codes, mstatus bit positions and FSM encoding
// for the core-local interrupt/trap sequencer.
package clint_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        T_WR_MEPC    = 3'd1,
        T_WR_MCAUSE  = 3'd2,
        T_WR_MSTATUS = 3'd3,
        T_JUMP       = 3'd4,
        R_RD_MSTATUS = 3'd5,
        R_WR_MSTATUS = 3'd6,
        R_JUMP       = 3'd7
    } state_e;

    // mstatus on trap entry: stash MIE into MPIE, then disable interrupts
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r           = s;
        r[MPIE_BIT] = s[MIE_BIT];
        r[MIE_BIT]  = 1'b0;
        return r;
    endfunction

    // mstatus on mret: restore MIE from MPIE, MPIE set to 1
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r           = s;
        r[MIE_BIT]  = s[MPIE_BIT];
        r[MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Port pair into the external CSR register file: combinational read,
// write committed on the next rising edge.
interface clint_if;
    logic        csr_re_o;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;

    modport master (
        output csr_re_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  csr_rdata_i
    );

    modport slave (
        input  csr_re_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output csr_rdata_i
    );
endinterface

// File: rtl/clint.sv
// Trap / mret sequencer. Walks the CSR file through the mepc/mcause/mstatus
// updates for a trap, or the mstatus restore for mret, stalling the pipeline
// and issuing a single-cycle redirect at the end.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | accept events; trap cycle reads mstatus, mret reads mepc
// T_WR_MEPC    | write mepc with the latched PC
// T_WR_MCAUSE  | write mcause with the latched cause
// T_WR_MSTATUS | write mstatus with MPIE=old MIE, MIE=0
// T_JUMP       | read mtvec, redirect to its base (mode bits dropped)
// R_RD_MSTATUS | read mstatus into the latch
// R_WR_MSTATUS | write mstatus with MIE=old MPIE, MPIE=1
// R_JUMP       | redirect to the latched mepc
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] IRQ_CAUSE = 32'h8000_0007
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ecall_i,
    input  logic         ebreak_i,
    input  logic         mret_i,
    input  logic [31:0]  inst_addr_i,
    input  logic         irq_i,
    input  logic         ex_csr_we_i,
    input  logic [11:0]  ex_csr_waddr_i,
    input  logic [31:0]  ex_csr_wdata_i,
    clint_if.master      csr,
    output logic         hold_o,
    output logic         jump_o,
    output logic [31:0]  jump_addr_o
);

    state_e      state, state_nxt;
    logic [31:0] pc_lat;
    logic [31:0] cause_lat;
    logic [31:0] mstatus_lat;
    logic        mie_shadow;

    logic        ld_trap;
    logic        ld_pc_rd;
    logic        ld_mstatus;
    logic        own_ms_wr;
    logic        own_mie;
    logic [31:0] cause_sel;
    logic        snoop_ms_wr;

    assign snoop_ms_wr = ex_csr_we_i && (ex_csr_waddr_i == CSR_MSTATUS);

    // Next-state and output decode; everything is forced to 0 while in reset
    always_comb begin
        state_nxt       = state;
        hold_o          = 1'b0;
        jump_o          = 1'b0;
        jump_addr_o     = 32'd0;
        csr.csr_re_o    = 1'b0;
        csr.csr_raddr_o = 12'd0;
        csr.csr_we_o    = 1'b0;
        csr.csr_waddr_o = 12'd0;
        csr.csr_wdata_o = 32'd0;
        ld_trap         = 1'b0;
        ld_pc_rd        = 1'b0;
        ld_mstatus      = 1'b0;
        own_ms_wr       = 1'b0;
        own_mie         = 1'b0;
        cause_sel       = 32'd0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (mret_i) begin
                        hold_o          = 1'b1;
                        csr.csr_re_o    = 1'b1;
                        csr.csr_raddr_o = CSR_MEPC;
                        ld_pc_rd        = 1'b1;
                        state_nxt       = R_RD_MSTATUS;
                    end else if (ecall_i || ebreak_i || (irq_i && mie_shadow)) begin
                        hold_o          = 1'b1;
                        csr.csr_re_o    = 1'b1;
                        csr.csr_raddr_o = CSR_MSTATUS;
                        ld_mstatus      = 1'b1;
                        ld_trap         = 1'b1;
                        state_nxt       = T_WR_MEPC;
                        if (ecall_i)       cause_sel = CAUSE_ECALL;
                        else if (ebreak_i) cause_sel = CAUSE_EBREAK;
                        else               cause_sel = IRQ_CAUSE;
                    end
                end
                T_WR_MEPC: begin
                    hold_o          = 1'b1;
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_MEPC;
                    csr.csr_wdata_o = pc_lat;
                    state_nxt       = T_WR_MCAUSE;
                end
                T_WR_MCAUSE: begin
                    hold_o          = 1'b1;
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_MCAUSE;
                    csr.csr_wdata_o = cause_lat;
                    state_nxt       = T_WR_MSTATUS;
                end
                T_WR_MSTATUS: begin
                    hold_o          = 1'b1;
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_MSTATUS;
                    csr.csr_wdata_o = trap_mstatus(mstatus_lat);
                    own_ms_wr       = 1'b1;
                    own_mie         = 1'b0;
                    state_nxt       = T_JUMP;
                end
                T_JUMP: begin
                    hold_o          = 1'b1;
                    csr.csr_re_o    = 1'b1;
                    csr.csr_raddr_o = CSR_MTVEC;
                    jump_o          = 1'b1;
                    jump_addr_o     = {csr.csr_rdata_i[31:2], 2'b00};
                    state_nxt       = IDLE;
                end
                R_RD_MSTATUS: begin
                    hold_o          = 1'b1;
                    csr.csr_re_o    = 1'b1;
                    csr.csr_raddr_o = CSR_MSTATUS;
                    ld_mstatus      = 1'b1;
                    state_nxt       = R_WR_MSTATUS;
                end
                R_WR_MSTATUS: begin
                    hold_o          = 1'b1;
                    csr.csr_we_o    = 1'b1;
                    csr.csr_waddr_o = CSR_MSTATUS;
                    csr.csr_wdata_o = mret_mstatus(mstatus_lat);
                    own_ms_wr       = 1'b1;
                    own_mie         = mstatus_lat[MPIE_BIT];
                    state_nxt       = R_JUMP;
                end
                R_JUMP: begin
                    hold_o          = 1'b1;
                    jump_o          = 1'b1;
                    jump_addr_o     = pc_lat;
                    state_nxt       = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // PC / cause / mstatus latches; pc_lat holds the trap PC or the mepc read by mret
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_lat      <= 32'd0;
            cause_lat   <= 32'd0;
            mstatus_lat <= 32'd0;
        end else begin
            if (ld_trap) begin
                pc_lat    <= inst_addr_i;
                cause_lat <= cause_sel;
            end
            if (ld_pc_rd)   pc_lat      <= csr.csr_rdata_i;
            if (ld_mstatus) mstatus_lat <= csr.csr_rdata_i;
        end
    end

    // Local copy of mstatus.MIE; our own mstatus write takes priority over a snooped one
    always_ff @(posedge clk) begin
        if (!rst_n)           mie_shadow <= 1'b0;
        else if (own_ms_wr)   mie_shadow <= own_mie;
        else if (snoop_ms_wr) mie_shadow <= ex_csr_wdata_i[MIE_BIT];
    end

endmodule

// File: tb/tb_clint.sv
// Bench for clint: behavioural CSR file on the slave side, expected CSR
// writes queued when stimulus is applied and popped as the DUT writes.
module tb_clint;
    import clint_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall_i, ebreak_i, mret_i, irq_i;
    logic [31:0] inst_addr_i;
    logic        ex_csr_we_i;
    logic [11:0] ex_csr_waddr_i;
    logic [31:0] ex_csr_wdata_i;
    logic        hold_o, jump_o;
    logic [31:0] jump_addr_o;

    clint_if bus();

    clint #(.IRQ_CAUSE(32'h8000_0007)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ecall_i        (ecall_i),
        .ebreak_i       (ebreak_i),
        .mret_i         (mret_i),
        .inst_addr_i    (inst_addr_i),
        .irq_i          (irq_i),
        .ex_csr_we_i    (ex_csr_we_i),
        .ex_csr_waddr_i (ex_csr_waddr_i),
        .ex_csr_wdata_i (ex_csr_wdata_i),
        .csr            (bus.master),
        .hold_o         (hold_o),
        .jump_o         (jump_o),
        .jump_addr_o    (jump_addr_o)
    );

    always #5 clk = ~clk;

    // CSR file model: DUT port has priority, else the pipeline write
    logic [31:0] m_mstatus = 32'd0;
    logic [31:0] m_mepc    = 32'd0;
    logic [31:0] m_mcause  = 32'd0;
    logic [31:0] m_mtvec   = 32'd0;

    always_comb begin
        bus.csr_rdata_i = 32'd0;
        if (bus.csr_re_o) begin
            case (bus.csr_raddr_o)
                CSR_MSTATUS: bus.csr_rdata_i = m_mstatus;
                CSR_MEPC:    bus.csr_rdata_i = m_mepc;
                CSR_MCAUSE:  bus.csr_rdata_i = m_mcause;
                CSR_MTVEC:   bus.csr_rdata_i = m_mtvec;
                default:     bus.csr_rdata_i = 32'd0;
            endcase
        end
    end

    logic        wr_en;
    logic [11:0] wr_a;
    logic [31:0] wr_d;
    assign wr_en = bus.csr_we_o | (ex_csr_we_i & rst_n);
    assign wr_a  = bus.csr_we_o ? bus.csr_waddr_o : ex_csr_waddr_i;
    assign wr_d  = bus.csr_we_o ? bus.csr_wdata_o : ex_csr_wdata_i;

    always @(posedge clk) begin
        if (wr_en) begin
            case (wr_a)
                CSR_MSTATUS: m_mstatus <= wr_d;
                CSR_MEPC:    m_mepc    <= wr_d;
                CSR_MCAUSE:  m_mcause  <= wr_d;
                CSR_MTVEC:   m_mtvec   <= wr_d;
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int vecs = 0;
    int errs = 0;

    function automatic logic [127:0] all_outs();
        return {hold_o, jump_o, jump_addr_o, bus.csr_re_o, bus.csr_raddr_o,
                bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o};
    endfunction

    // pipeline CSR write for one cycle; returns at posedge+1 of the following cycle
    task automatic ex_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ex_csr_we_i = 1'b1; ex_csr_waddr_i = a; ex_csr_wdata_i = d;
        @(posedge clk); #1;
        ex_csr_we_i = 1'b0; ex_csr_waddr_i = 12'd0; ex_csr_wdata_i = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ecall_i = 1'b1; ebreak_i = 1'b0; mret_i = 1'b1; irq_i = 1'b1;
        inst_addr_i = 32'hdead_beef;
        ex_csr_we_i = 1'b0; ex_csr_waddr_i = 12'd0; ex_csr_wdata_i = 32'd0;
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (all_outs() !== '0) begin
                errs++; $display("FAIL reset_outs got=%h exp=0", all_outs());
            end
        end
        @(posedge clk); #1;
        ecall_i = 1'b0; mret_i = 1'b0; rst_n = 1'b1;
        // irq still high but MIE shadow cleared by reset: must stay idle
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (all_outs() !== '0) begin
                errs++; $display("FAIL idle_outs got=%h exp=0", all_outs());
            end
        end
        @(posedge clk); #1;
        irq_i = 1'b0;
    endtask

    task automatic test_ecall();
        wr_t w;
        ex_write(CSR_MSTATUS, 32'h0000_0008);
        ex_write(CSR_MTVEC,   32'h0000_0203);
        exp_q.push_back('{CSR_MEPC,    32'h0000_0100});
        exp_q.push_back('{CSR_MCAUSE,  32'd11});
        exp_q.push_back('{CSR_MSTATUS, 32'h0000_0080});
        ecall_i = 1'b1; inst_addr_i = 32'h0000_0100;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, jump_o} !== {c <= 5, c == 5}) begin
                errs++; $display("FAIL ecall_hold_jump c=%0d got=%b%b exp=%b%b",
                                 c, hold_o, jump_o, c <= 5, c == 5);
            end
            if (c == 1) begin
                vecs++;
                if ({bus.csr_re_o, bus.csr_raddr_o, bus.csr_we_o} !== {1'b1, CSR_MSTATUS, 1'b0}) begin
                    errs++; $display("FAIL ecall_rd_mstatus got=%b/%h/%b exp=1/300/0",
                                     bus.csr_re_o, bus.csr_raddr_o, bus.csr_we_o);
                end
            end
            if (c == 5) begin
                vecs++;
                if (jump_addr_o !== 32'h0000_0200) begin
                    errs++; $display("FAIL ecall_jump_addr got=%h exp=00000200", jump_addr_o);
                end
            end
            if (bus.csr_we_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL ecall_extra_write got=%h:%h exp=none",
                                     bus.csr_waddr_o, bus.csr_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {w.a, w.d}) begin
                        errs++; $display("FAIL ecall_write got=%h:%h exp=%h:%h",
                                         bus.csr_waddr_o, bus.csr_wdata_o, w.a, w.d);
                    end
                end
            end
            @(posedge clk); #1;
            ecall_i = 1'b0;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL ecall_missing_writes got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_mret();
        wr_t w;
        ex_write(CSR_MEPC,    32'h0000_0104);
        ex_write(CSR_MSTATUS, 32'h0000_0080);
        exp_q.push_back('{CSR_MSTATUS, 32'h0000_0088});
        mret_i = 1'b1; inst_addr_i = 32'h0000_0400;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, jump_o} !== {c <= 4, c == 4}) begin
                errs++; $display("FAIL mret_hold_jump c=%0d got=%b%b exp=%b%b",
                                 c, hold_o, jump_o, c <= 4, c == 4);
            end
            if (c == 4) begin
                vecs++;
                if (jump_addr_o !== 32'h0000_0104) begin
                    errs++; $display("FAIL mret_jump_addr got=%h exp=00000104", jump_addr_o);
                end
            end
            if (bus.csr_we_o) begin
                vecs++;
                if (bus.csr_re_o && bus.csr_raddr_o == bus.csr_waddr_o) begin
                    errs++; $display("FAIL mret_rw_clash got=re+we exp=we only");
                end
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL mret_extra_write got=%h:%h exp=none",
                                     bus.csr_waddr_o, bus.csr_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {w.a, w.d}) begin
                        errs++; $display("FAIL mret_write got=%h:%h exp=%h:%h",
                                         bus.csr_waddr_o, bus.csr_wdata_o, w.a, w.d);
                    end
                end
            end
            @(posedge clk); #1;
            mret_i = 1'b0;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL mret_missing_writes got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_irq_enable();
        wr_t w;
        ex_write(CSR_MSTATUS, 32'h0000_0000);
        irq_i = 1'b1; inst_addr_i = 32'h0000_0240;
        repeat (4) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, bus.csr_we_o, bus.csr_re_o} !== 3'b000) begin
                errs++; $display("FAIL irq_masked got=%b%b%b exp=000",
                                 hold_o, bus.csr_we_o, bus.csr_re_o);
            end
        end
        exp_q.push_back('{CSR_MEPC,    32'h0000_0240});
        exp_q.push_back('{CSR_MCAUSE,  32'h8000_0007});
        exp_q.push_back('{CSR_MSTATUS, 32'h0000_0080});
        ex_write(CSR_MSTATUS, 32'h0000_0008);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, jump_o} !== {c <= 5, c == 5}) begin
                errs++; $display("FAIL irq_hold_jump c=%0d got=%b%b exp=%b%b",
                                 c, hold_o, jump_o, c <= 5, c == 5);
            end
            if (bus.csr_we_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL irq_extra_write got=%h:%h exp=none",
                                     bus.csr_waddr_o, bus.csr_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {w.a, w.d}) begin
                        errs++; $display("FAIL irq_write got=%h:%h exp=%h:%h",
                                         bus.csr_waddr_o, bus.csr_wdata_o, w.a, w.d);
                    end
                end
            end
            @(posedge clk); #1;
            irq_i = 1'b0;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL irq_missing_writes got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_ecall_irq();
        wr_t w;
        ex_write(CSR_MSTATUS, 32'h0000_0008);
        exp_q.push_back('{CSR_MEPC,    32'h0000_0180});
        exp_q.push_back('{CSR_MCAUSE,  32'd11});
        exp_q.push_back('{CSR_MSTATUS, 32'h0000_0080});
        ecall_i = 1'b1; irq_i = 1'b1; inst_addr_i = 32'h0000_0180;
        // irq stays high; after the ecall trap MIE is 0 so it must wait
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, jump_o} !== {c <= 5, c == 5}) begin
                errs++; $display("FAIL ecirq_hold_jump c=%0d got=%b%b exp=%b%b",
                                 c, hold_o, jump_o, c <= 5, c == 5);
            end
            if (bus.csr_we_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL ecirq_extra_write got=%h:%h exp=none",
                                     bus.csr_waddr_o, bus.csr_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {w.a, w.d}) begin
                        errs++; $display("FAIL ecirq_write got=%h:%h exp=%h:%h",
                                         bus.csr_waddr_o, bus.csr_wdata_o, w.a, w.d);
                    end
                end
            end
            @(posedge clk); #1;
            ecall_i = 1'b0;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL ecirq_missing_writes got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
        exp_q.push_back('{CSR_MEPC,    32'h0000_0180});
        exp_q.push_back('{CSR_MCAUSE,  32'h8000_0007});
        exp_q.push_back('{CSR_MSTATUS, 32'h0000_0080});
        ex_write(CSR_MSTATUS, 32'h0000_0008);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vecs++;
            if ({hold_o, jump_o} !== {c <= 5, c == 5}) begin
                errs++; $display("FAIL ecirq2_hold_jump c=%0d got=%b%b exp=%b%b",
                                 c, hold_o, jump_o, c <= 5, c == 5);
            end
            if (bus.csr_we_o) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL ecirq2_extra_write got=%h:%h exp=none",
                                     bus.csr_waddr_o, bus.csr_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if ({bus.csr_waddr_o, bus.csr_wdata_o} !== {w.a, w.d}) begin
                        errs++; $display("FAIL ecirq2_write got=%h:%h exp=%h:%h",
                                         bus.csr_waddr_o, bus.csr_wdata_o, w.a, w.d);
                    end
                end
            end
            @(posedge clk); #1;
            irq_i = 1'b0;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL ecirq2_missing_writes got=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mc_before, ms_before;
        ex_write(CSR_MSTATUS, 32'h0000_0008);
        mc_before = m_mcause;
        ms_before = m_mstatus;
        ecall_i = 1'b1; inst_addr_i = 32'h0000_0300;
        @(negedge clk);
        @(posedge clk); #1;
        ecall_i = 1'b0;
        @(negedge clk);
        vecs++;
        if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, CSR_MEPC, 32'h0000_0300}) begin
            errs++; $display("FAIL rmid_mepc_write got=%b:%h:%h exp=1:341:00000300",
                             bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if (all_outs() !== '0) begin
            errs++; $display("FAIL rmid_outs_in_reset got=%h exp=0", all_outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1; irq_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vecs++;
            if (all_outs() !== '0) begin
                errs++; $display("FAIL rmid_outs_after c=%0d got=%h exp=0", c, all_outs());
            end
        end
        irq_i = 1'b0;
        vecs++;
        if ({m_mepc, m_mcause, m_mstatus} !== {32'h0000_0300, mc_before, ms_before}) begin
            errs++; $display("FAIL rmid_csr_state got=%h/%h/%h exp=00000300/%h/%h",
                             m_mepc, m_mcause, m_mstatus, mc_before, ms_before);
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_irq_enable();
        test_ecall_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
